ysyx_22050550_lsu: RTL and testbench
====================================

# ysyx_22050550_lsu

Load/store stage of the ysyx_22050550 five-stage core, between EXU and WBU. Accepts one instruction at a time from EXU over a valid/ready handshake and runs any load or store on a single-outstanding memory request/response port. Formats load data (byte select, sign/zero extension) and registers the result into the LS→WB bundle consumed by the write-back unit.

## Interface
Parameters:
- SIDE_W, 96: width of opaque sideband (csr/ecall/mret/jalr/ebreak/SkipRef flags, rs1addr, imm, NextPc bits), carried unchanged.

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- io_EXLS_valid  in  1  EXU holds a valid instruction
- io_EXLS_ready  out  1  LSU accepts this cycle
- io_EXLS_pc  in  64  instruction pc
- io_EXLS_inst  in  32  instruction word
- io_EXLS_alures  in  64  ALU result; effective address for load/store
- io_EXLS_rs2  in  64  store data
- io_EXLS_func3  in  3  access size/sign
- io_EXLS_readflag  in  1  load
- io_EXLS_writeflag  in  1  store
- io_EXLS_wen  in  1  GPR write enable
- io_EXLS_waddr  in  5  GPR index
- io_EXLS_side  in  SIDE_W  sideband
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  64  8-byte-aligned address (alures & ~7)
- mem_req_wen  out  1  1 = store
- mem_req_wdata  out  64  store data shifted to byte lane
- mem_req_wmask  out  8  byte strobes
- mem_resp_valid  in  1  response (load data or store ack)
- mem_resp_rdata  in  64  aligned load doubleword
- io_LSWB_valid  out  1  bundle valid to WBU
- io_ReadyWB_ready  in  1  WBU accepts bundle
- io_LSWB_pc/inst/alures/readflag/wen/waddr/side  out  64/32/64/1/1/5/SIDE_W  registered copies
- io_LSWB_lsures  out  64  formatted load result (0 for non-loads)
- io_LSWB_abort  out  1  access fault (see Configuration)

## Operation
- FSM states: IDLE, REQ, WAIT, OUT.
- io_EXLS_ready = (state==IDLE) && (!io_LSWB_valid || io_ReadyWB_ready).
- Accept in IDLE: capture all io_EXLS_* fields. Non-memory → OUT directly. Load or store → REQ.
- REQ: mem_req_valid=1, fields stable until mem_req_ready; on handshake → WAIT.
- WAIT: mem_resp_valid → capture/format rdata (loads), → OUT. Stores complete on ack, lsures=0.
- OUT: io_LSWB_valid=1; held with all fields stable until io_ReadyWB_ready → IDLE.
- off = alures[2:0]. Load extract rdata >> (8*off), then func3: 000 lb sext8, 001 lh sext16, 010 lw sext32, 011 ld, 100 lbu, 101 lhu, 110 lwu zext; 111 → 0.
- Store: func3 000 mask 8'h01, 001 8'h03, 010 8'h0F, 011 8'hFF, shifted left by off; wdata = rs2 << (8*off).
- mem_resp_valid outside WAIT ignored. readflag && writeflag together: treated as load.

## Timing
- Reset (async): state=IDLE, io_LSWB_valid=0, mem_req_valid=0, all other registered outputs 0, io_LSWB_abort=0.
- Non-memory: accepted cycle N → io_LSWB_valid at N+1.
- Memory with mem_req_ready=1 on first cycle, response k cycles later: accept N, req at N+1, resp N+1+k, io_LSWB_valid N+2+k.
- One instruction in flight; io_EXLS_ready low in REQ/WAIT/OUT, except OUT→IDLE: ready asserts the cycle after WB handshake (no same-cycle back-to-back).
- Reset during REQ/WAIT abandons the access; late response ignored.

## Configuration
- YSYX_22050550_LSU_MISALIGN_EN defined: access with off not aligned to size (lh/sh off[0]≠0, lw/sw off[1:0]≠0, ld/sd off≠0) skips REQ/WAIT, goes to OUT with io_LSWB_abort=1, lsures=0, wen forced 0.
- Undefined: no check; abort tied 0; misaligned access uses truncated lanes (bytes beyond lane 7 dropped).

## Test plan
- Reset mid-WAIT of ld → next cycle state IDLE, mem_req_valid=0, io_LSWB_valid=0; response arriving after is ignored.
- ALU op alures=0x1234, wen=1, waddr=5, ReadyWB=1 → io_LSWB_valid one cycle after accept, alures=0x1234, lsures=0.
- lb at 0x80000003, rdata=0x00000000_80000000 → lsures=0xFFFFFFFF_FFFFFF80; lbu → 0x80.
- sh at 0x80000006, rs2=0xBEEF → mem_req_addr=0x80000000, wmask=0xC0, wdata=0xBEEF_0000_0000_0000, mem_req_wen=1.
- mem_req_ready low 3 cycles, ReadyWB low 2 cycles in OUT → request fields and LSWB bundle stable throughout; io_EXLS_ready low until after WB handshake.
- With MISALIGN_EN, lw at 0x80000002 → no mem_req_valid, abort=1, wen=0; without it, request issued with wmask=0x3C.

Source files
------------

// File: rtl/ysyx_22050550_lsu.sv
// rtl/ysyx_22050550_lsu.sv - load/store stage: EXU handshake, single-outstanding memory port, load formatting
// Optional misaligned-access fault enabled by defining YSYX_22050550_LSU_MISALIGN_EN
module ysyx_22050550_lsu #(
  parameter int SIDE_W = 96
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_EXLS_valid,
  output logic              io_EXLS_ready,
  input  logic [63:0]       io_EXLS_pc,
  input  logic [31:0]       io_EXLS_inst,
  input  logic [63:0]       io_EXLS_alures,
  input  logic [63:0]       io_EXLS_rs2,
  input  logic [2:0]        io_EXLS_func3,
  input  logic              io_EXLS_readflag,
  input  logic              io_EXLS_writeflag,
  input  logic              io_EXLS_wen,
  input  logic [4:0]        io_EXLS_waddr,
  input  logic [SIDE_W-1:0] io_EXLS_side,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [63:0]       mem_req_addr,
  output logic              mem_req_wen,
  output logic [63:0]       mem_req_wdata,
  output logic [7:0]        mem_req_wmask,
  input  logic              mem_resp_valid,
  input  logic [63:0]       mem_resp_rdata,
  output logic              io_LSWB_valid,
  input  logic              io_ReadyWB_ready,
  output logic [63:0]       io_LSWB_pc,
  output logic [31:0]       io_LSWB_inst,
  output logic [63:0]       io_LSWB_alures,
  output logic              io_LSWB_readflag,
  output logic              io_LSWB_wen,
  output logic [4:0]        io_LSWB_waddr,
  output logic [SIDE_W-1:0] io_LSWB_side,
  output logic [63:0]       io_LSWB_lsures,
  output logic              io_LSWB_abort
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_OUT} state_e;
  state_e state_q, state_d;

  logic [63:0]       pc_q, alures_q, wdata_q, lsures_q, lsures_d;
  logic [31:0]       inst_q;
  logic [2:0]        func3_q;
  logic              readflag_q, store_q, wen_q, abort_q;
  logic [4:0]        waddr_q;
  logic [SIDE_W-1:0] side_q;
  logic [7:0]        wmask_q, mask_base, wmask_d;
  logic [63:0]       wdata_d, rdata_sh;
  logic [2:0]        off_in;
  logic              accept, mem_op, fault;

  assign io_EXLS_ready = (state_q == S_IDLE) && (!io_LSWB_valid || io_ReadyWB_ready);
  assign accept        = io_EXLS_valid && io_EXLS_ready;
  assign off_in        = io_EXLS_alures[2:0];
  assign mem_op        = io_EXLS_readflag || io_EXLS_writeflag;

  always_comb begin
    mask_base = 8'h00;
    case (io_EXLS_func3[1:0])
      2'b00:   mask_base = 8'h01;
      2'b01:   mask_base = 8'h03;
      2'b10:   mask_base = 8'h0F;
      default: mask_base = 8'hFF;
    endcase
  end

  // Lanes shifted past byte 7 fall off the top when misaligned accesses are let through.
  assign wmask_d = mask_base << off_in;
  assign wdata_d = io_EXLS_rs2 << {off_in, 3'b000};

`ifdef YSYX_22050550_LSU_MISALIGN_EN
  logic misalign;
  always_comb begin
    misalign = 1'b0;
    case (io_EXLS_func3[1:0])
      2'b01:   misalign = off_in[0];
      2'b10:   misalign = |off_in[1:0];
      2'b11:   misalign = |off_in;
      default: misalign = 1'b0;
    endcase
  end
  assign fault = mem_op && misalign;
`else
  assign fault = 1'b0;
`endif

  assign rdata_sh = mem_resp_rdata >> {alures_q[2:0], 3'b000};

  always_comb begin
    lsures_d = 64'h0;
    case (func3_q)
      3'b000: lsures_d = {{56{rdata_sh[7]}}, rdata_sh[7:0]};
      3'b001: lsures_d = {{48{rdata_sh[15]}}, rdata_sh[15:0]};
      3'b010: lsures_d = {{32{rdata_sh[31]}}, rdata_sh[31:0]};
      3'b011: lsures_d = rdata_sh;
      3'b100: lsures_d = {56'h0, rdata_sh[7:0]};
      3'b101: lsures_d = {48'h0, rdata_sh[15:0]};
      3'b110: lsures_d = {32'h0, rdata_sh[31:0]};
      default: lsures_d = 64'h0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) begin
        if (mem_op && !fault) state_d = S_REQ;
        else                  state_d = S_OUT;
      end
      S_REQ:  if (mem_req_ready)    state_d = S_WAIT;
      S_WAIT: if (mem_resp_valid)   state_d = S_OUT;
      S_OUT:  if (io_ReadyWB_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q       <= 64'h0;
      inst_q     <= 32'h0;
      alures_q   <= 64'h0;
      func3_q    <= 3'h0;
      readflag_q <= 1'b0;
      store_q    <= 1'b0;
      wen_q      <= 1'b0;
      waddr_q    <= 5'h0;
      side_q     <= '0;
      wdata_q    <= 64'h0;
      wmask_q    <= 8'h0;
      lsures_q   <= 64'h0;
      abort_q    <= 1'b0;
    end else if (accept) begin
      pc_q       <= io_EXLS_pc;
      inst_q     <= io_EXLS_inst;
      alures_q   <= io_EXLS_alures;
      func3_q    <= io_EXLS_func3;
      readflag_q <= io_EXLS_readflag;
      store_q    <= io_EXLS_writeflag && !io_EXLS_readflag;
      wen_q      <= io_EXLS_wen && !fault;
      waddr_q    <= io_EXLS_waddr;
      side_q     <= io_EXLS_side;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      lsures_q   <= 64'h0;
      abort_q    <= fault;
    end else if (state_q == S_WAIT && mem_resp_valid && readflag_q) begin
      lsures_q   <= lsures_d;
    end
  end

  assign mem_req_valid    = (state_q == S_REQ);
  assign mem_req_addr     = {alures_q[63:3], 3'b000};
  assign mem_req_wen      = store_q;
  assign mem_req_wdata    = wdata_q;
  assign mem_req_wmask    = wmask_q;
  assign io_LSWB_valid    = (state_q == S_OUT);
  assign io_LSWB_pc       = pc_q;
  assign io_LSWB_inst     = inst_q;
  assign io_LSWB_alures   = alures_q;
  assign io_LSWB_readflag = readflag_q;
  assign io_LSWB_wen      = wen_q;
  assign io_LSWB_waddr    = waddr_q;
  assign io_LSWB_side     = side_q;
  assign io_LSWB_lsures   = lsures_q;
  assign io_LSWB_abort    = abort_q;
endmodule

// File: tb/tb_ysyx_22050550_lsu.sv
// tb/tb_ysyx_22050550_lsu.sv - directed self-checking bench for ysyx_22050550_lsu
module tb_ysyx_22050550_lsu;
  localparam int SIDE_W = 96;

  logic              clock = 1'b0;
  logic              reset;
  logic              io_EXLS_valid, io_EXLS_ready;
  logic [63:0]       io_EXLS_pc, io_EXLS_alures, io_EXLS_rs2;
  logic [31:0]       io_EXLS_inst;
  logic [2:0]        io_EXLS_func3;
  logic              io_EXLS_readflag, io_EXLS_writeflag, io_EXLS_wen;
  logic [4:0]        io_EXLS_waddr;
  logic [SIDE_W-1:0] io_EXLS_side;
  logic              mem_req_valid, mem_req_ready, mem_req_wen;
  logic [63:0]       mem_req_addr, mem_req_wdata;
  logic [7:0]        mem_req_wmask;
  logic              mem_resp_valid;
  logic [63:0]       mem_resp_rdata;
  logic              io_LSWB_valid, io_ReadyWB_ready;
  logic [63:0]       io_LSWB_pc, io_LSWB_alures, io_LSWB_lsures;
  logic [31:0]       io_LSWB_inst;
  logic              io_LSWB_readflag, io_LSWB_wen, io_LSWB_abort;
  logic [4:0]        io_LSWB_waddr;
  logic [SIDE_W-1:0] io_LSWB_side;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  ysyx_22050550_lsu #(.SIDE_W(SIDE_W)) dut (
    .clock(clock), .reset(reset),
    .io_EXLS_valid(io_EXLS_valid), .io_EXLS_ready(io_EXLS_ready),
    .io_EXLS_pc(io_EXLS_pc), .io_EXLS_inst(io_EXLS_inst),
    .io_EXLS_alures(io_EXLS_alures), .io_EXLS_rs2(io_EXLS_rs2),
    .io_EXLS_func3(io_EXLS_func3), .io_EXLS_readflag(io_EXLS_readflag),
    .io_EXLS_writeflag(io_EXLS_writeflag), .io_EXLS_wen(io_EXLS_wen),
    .io_EXLS_waddr(io_EXLS_waddr), .io_EXLS_side(io_EXLS_side),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .io_LSWB_valid(io_LSWB_valid), .io_ReadyWB_ready(io_ReadyWB_ready),
    .io_LSWB_pc(io_LSWB_pc), .io_LSWB_inst(io_LSWB_inst),
    .io_LSWB_alures(io_LSWB_alures), .io_LSWB_readflag(io_LSWB_readflag),
    .io_LSWB_wen(io_LSWB_wen), .io_LSWB_waddr(io_LSWB_waddr),
    .io_LSWB_side(io_LSWB_side), .io_LSWB_lsures(io_LSWB_lsures),
    .io_LSWB_abort(io_LSWB_abort)
  );

  task automatic drive_ex(input logic [63:0] alures, input logic [63:0] rs2, input logic [2:0] f3,
                          input logic rd, input logic wr, input logic wen, input logic [4:0] waddr);
    io_EXLS_pc        = 64'h0000_0000_8000_1000;
    io_EXLS_inst      = 32'h0000_0013;
    io_EXLS_alures    = alures;
    io_EXLS_rs2       = rs2;
    io_EXLS_func3     = f3;
    io_EXLS_readflag  = rd;
    io_EXLS_writeflag = wr;
    io_EXLS_wen       = wen;
    io_EXLS_waddr     = waddr;
    io_EXLS_side      = {32'h1111_2222, 32'h3333_4444, 32'h5555_6666};
  endtask

  // Runs one memory instruction from IDLE back to IDLE and reports what was observed.
  task automatic mem_txn(input logic [63:0] alures, input logic [63:0] rs2, input logic [2:0] f3,
                         input logic rd, input logic wr, input logic [63:0] rdata,
                         output logic req_seen, output logic [63:0] addr, output logic [63:0] wdata,
                         output logic [7:0] wmask, output logic mwen, output logic got_out,
                         output logic [63:0] lsures, output logic abort, output logic lwen);
    drive_ex(alures, rs2, f3, rd, wr, 1'b1, 5'd7);
    io_EXLS_valid = 1'b1;
    @(posedge clock); #1;
    io_EXLS_valid = 1'b0;
    req_seen = mem_req_valid;
    addr = mem_req_addr; wdata = mem_req_wdata; wmask = mem_req_wmask; mwen = mem_req_wen;
    if (req_seen) begin
      mem_req_ready = 1'b1;
      @(posedge clock); #1;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_rdata = rdata;
      @(posedge clock); #1;
      mem_resp_valid = 1'b0;
    end
    for (int i = 0; i < 10 && !io_LSWB_valid; i++) begin
      @(posedge clock); #1;
    end
    got_out = io_LSWB_valid;
    lsures = io_LSWB_lsures; abort = io_LSWB_abort; lwen = io_LSWB_wen;
    io_ReadyWB_ready = 1'b1;
    @(posedge clock); #1;
    io_ReadyWB_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    io_EXLS_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    mem_resp_rdata = 64'h0; io_ReadyWB_ready = 1'b0;
    drive_ex(64'h0, 64'h0, 3'b000, 1'b0, 1'b0, 1'b0, 5'd0);
    repeat (2) @(posedge clock);
    #1;
    n_checks++; if (io_LSWB_valid !== 1'b0) begin n_fail++; $display("FAIL reset_lswb_valid: got %b expected 0", io_LSWB_valid); end
    n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b expected 0", mem_req_valid); end
    n_checks++; if (io_LSWB_lsures !== 64'h0 || io_LSWB_alures !== 64'h0) begin n_fail++; $display("FAIL reset_data: lsures %h alures %h expected 0", io_LSWB_lsures, io_LSWB_alures); end
    n_checks++; if (io_LSWB_abort !== 1'b0) begin n_fail++; $display("FAIL reset_abort: got %b expected 0", io_LSWB_abort); end
    reset = 1'b0;
    @(posedge clock); #1;
    n_checks++; if (io_EXLS_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", io_EXLS_ready); end
  endtask

  task automatic test_alu;
    drive_ex(64'h1234, 64'h0, 3'b000, 1'b0, 1'b0, 1'b1, 5'd5);
    io_ReadyWB_ready = 1'b1;
    io_EXLS_valid = 1'b1;
    @(posedge clock); #1;
    io_EXLS_valid = 1'b0;
    n_checks++; if (io_LSWB_valid !== 1'b1) begin n_fail++; $display("FAIL alu_valid_latency: got %b expected 1", io_LSWB_valid); end
    n_checks++; if (io_LSWB_alures !== 64'h1234 || io_LSWB_lsures !== 64'h0) begin n_fail++; $display("FAIL alu_data: alures %h lsures %h expected 1234 0", io_LSWB_alures, io_LSWB_lsures); end
    n_checks++; if (io_LSWB_wen !== 1'b1 || io_LSWB_waddr !== 5'd5 || io_LSWB_readflag !== 1'b0) begin n_fail++; $display("FAIL alu_ctrl: wen %b waddr %0d rd %b expected 1 5 0", io_LSWB_wen, io_LSWB_waddr, io_LSWB_readflag); end
    n_checks++; if (io_LSWB_pc !== 64'h8000_1000 || io_LSWB_inst !== 32'h13 || io_LSWB_side !== {32'h1111_2222, 32'h3333_4444, 32'h5555_6666}) begin n_fail++; $display("FAIL alu_passthru: pc %h inst %h side %h", io_LSWB_pc, io_LSWB_inst, io_LSWB_side); end
    n_checks++; if (mem_req_valid !== 1'b0 || io_EXLS_ready !== 1'b0) begin n_fail++; $display("FAIL alu_out_state: req %b ready %b expected 0 0", mem_req_valid, io_EXLS_ready); end
    @(posedge clock); #1;
    io_ReadyWB_ready = 1'b0;
    n_checks++; if (io_LSWB_valid !== 1'b0 || io_EXLS_ready !== 1'b1) begin n_fail++; $display("FAIL alu_release: valid %b ready %b expected 0 1", io_LSWB_valid, io_EXLS_ready); end
  endtask

  task automatic test_loads;
    logic rs, mw, go, ab, lw;
    logic [63:0] ad, wd, ls;
    logic [7:0] wm;
    mem_txn(64'h8000_0003, 64'h0, 3'b000, 1'b1, 1'b0, 64'h0000_0000_8000_0000, rs, ad, wd, wm, mw, go, ls, ab, lw);
    n_checks++; if (rs !== 1'b1 || ad !== 64'h8000_0000 || mw !== 1'b0) begin n_fail++; $display("FAIL lb_req: seen %b addr %h wen %b expected 1 80000000 0", rs, ad, mw); end
    n_checks++; if (go !== 1'b1 || ls !== 64'hFFFF_FFFF_FFFF_FF80) begin n_fail++; $display("FAIL lb_lsures: out %b got %h expected ffffffffffffff80", go, ls); end
    mem_txn(64'h8000_0003, 64'h0, 3'b100, 1'b1, 1'b0, 64'h0000_0000_8000_0000, rs, ad, wd, wm, mw, go, ls, ab, lw);
    n_checks++; if (go !== 1'b1 || ls !== 64'h80) begin n_fail++; $display("FAIL lbu_lsures: got %h expected 80", ls); end
    mem_txn(64'h8000_0008, 64'h0, 3'b011, 1'b1, 1'b0, 64'h0123_4567_89AB_CDEF, rs, ad, wd, wm, mw, go, ls, ab, lw);
    n_checks++; if (ad !== 64'h8000_0008 || ls !== 64'h0123_4567_89AB_CDEF) begin n_fail++; $display("FAIL ld_lsures: addr %h got %h expected 80000008 0123456789abcdef", ad, ls); end
    mem_txn(64'h8000_0004, 64'h0, 3'b010, 1'b1, 1'b0, 64'h8765_4321_0000_0000, rs, ad, wd, wm, mw, go, ls, ab, lw);
    n_checks++; if (ls !== 64'hFFFF_FFFF_8765_4321) begin n_fail++; $display("FAIL lw_sext: got %h expected ffffffff87654321", ls); end
    mem_txn(64'h8000_0002, 64'h0, 3'b101, 1'b1, 1'b0, 64'h0000_0000_ABCD_0000, rs, ad, wd, wm, mw, go, ls, ab, lw);
    n_checks++; if (ls !== 64'hABCD) begin n_fail++; $display("FAIL lhu_zext: got %h expected abcd", ls); end
    mem_txn(64'h8000_0000, 64'h55, 3'b111, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, rs, ad, wd, wm, mw, go, ls, ab, lw);
    n_checks++; if (ls !== 64'h0) begin n_fail++; $display("FAIL f3_111_zero: got %h expected 0", ls); end
    mem_txn(64'h8000_0000, 64'h55, 3'b011, 1'b1, 1'b1, 64'h42, rs, ad, wd, wm, mw, go, ls, ab, lw);
    n_checks++; if (mw !== 1'b0 || ls !== 64'h42) begin n_fail++; $display("FAIL rdwr_as_load: wen %b lsures %h expected 0 42", mw, ls); end
  endtask

  task automatic test_store;
    logic rs, mw, go, ab, lw;
    logic [63:0] ad, wd, ls;
    logic [7:0] wm;
    mem_txn(64'h8000_0006, 64'hBEEF, 3'b001, 1'b0, 1'b1, 64'hDEAD, rs, ad, wd, wm, mw, go, ls, ab, lw);
    n_checks++; if (ad !== 64'h8000_0000 || wm !== 8'hC0 || mw !== 1'b1) begin n_fail++; $display("FAIL sh_req: addr %h mask %h wen %b expected 80000000 c0 1", ad, wm, mw); end
    n_checks++; if (wd !== 64'hBEEF_0000_0000_0000) begin n_fail++; $display("FAIL sh_wdata: got %h expected beef000000000000", wd); end
    n_checks++; if (go !== 1'b1 || ls !== 64'h0) begin n_fail++; $display("FAIL sh_lsures: out %b got %h expected 0", go, ls); end
    mem_txn(64'h8000_0001, 64'h1234_56AB, 3'b000, 1'b0, 1'b1, 64'h0, rs, ad, wd, wm, mw, go, ls, ab, lw);
    n_checks++; if (wm !== 8'h02 || wd !== 64'h1234_56AB_00) begin n_fail++; $display("FAIL sb_lane: mask %h wdata %h expected 02 123456ab00", wm, wd); end
  endtask

  task automatic test_misalign;
    logic rs, mw, go, ab, lw;
    logic [63:0] ad, wd, ls;
    logic [7:0] wm;
    mem_txn(64'h8000_0002, 64'h0, 3'b010, 1'b1, 1'b0, 64'h0000_1122_3344_0000, rs, ad, wd, wm, mw, go, ls, ab, lw);
`ifdef YSYX_22050550_LSU_MISALIGN_EN
    n_checks++; if (rs !== 1'b0) begin n_fail++; $display("FAIL misalign_noreq: req seen %b expected 0", rs); end
    n_checks++; if (go !== 1'b1 || ab !== 1'b1 || lw !== 1'b0 || ls !== 64'h0) begin n_fail++; $display("FAIL misalign_abort: out %b abort %b wen %b lsures %h expected 1 1 0 0", go, ab, lw, ls); end
`else
    n_checks++; if (rs !== 1'b1 || wm !== 8'h3C) begin n_fail++; $display("FAIL misalign_req: seen %b mask %h expected 1 3c", rs, wm); end
    n_checks++; if (ab !== 1'b0 || lw !== 1'b1 || ls !== 64'h1122_3344) begin n_fail++; $display("FAIL misalign_load: abort %b wen %b lsures %h expected 0 1 11223344", ab, lw, ls); end
`endif
  endtask

  task automatic test_back_to_back_stall;
    drive_ex(64'h8000_0010, 64'h1122_3344_5566_7788, 3'b011, 1'b0, 1'b1, 1'b0, 5'd0);
    io_EXLS_valid = 1'b1;
    @(posedge clock); #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0010 || mem_req_wdata !== 64'h1122_3344_5566_7788 ||
          mem_req_wmask !== 8'hFF || io_EXLS_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_req_%0d: valid %b addr %h wdata %h mask %h ready %b", i, mem_req_valid, mem_req_addr, mem_req_wdata, mem_req_wmask, io_EXLS_ready);
      end
      @(posedge clock); #1;
    end
    mem_req_ready = 1'b1;
    @(posedge clock); #1;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1;
    @(posedge clock); #1;
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (io_LSWB_valid !== 1'b1 || io_LSWB_alures !== 64'h8000_0010 || io_LSWB_lsures !== 64'h0 || io_EXLS_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_out_%0d: valid %b alures %h lsures %h ready %b", i, io_LSWB_valid, io_LSWB_alures, io_LSWB_lsures, io_EXLS_ready);
      end
      @(posedge clock); #1;
    end
    io_ReadyWB_ready = 1'b1;
    #1;
    n_checks++; if (io_EXLS_ready !== 1'b0) begin n_fail++; $display("FAIL no_same_cycle_accept: ready %b expected 0", io_EXLS_ready); end
    @(posedge clock); #1;
    io_ReadyWB_ready = 1'b0;
    io_EXLS_valid = 1'b0;
    n_checks++; if (io_LSWB_valid !== 1'b0 || io_EXLS_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release: valid %b ready %b expected 0 1", io_LSWB_valid, io_EXLS_ready); end
  endtask

  task automatic test_reset_mid_wait;
    drive_ex(64'h8000_0008, 64'h0, 3'b011, 1'b1, 1'b0, 1'b1, 5'd3);
    io_EXLS_valid = 1'b1;
    @(posedge clock); #1;
    io_EXLS_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(posedge clock); #1;
    mem_req_ready = 1'b0;
    reset = 1'b1;
    #1;
    n_checks++; if (mem_req_valid !== 1'b0 || io_LSWB_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wait_clear: req %b valid %b expected 0 0", mem_req_valid, io_LSWB_valid); end
    @(posedge clock); #1;
    reset = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'hDEAD_BEEF;
    @(posedge clock); #1;
    mem_resp_valid = 1'b0;
    n_checks++; if (io_LSWB_valid !== 1'b0 || mem_req_valid !== 1'b0 || io_EXLS_ready !== 1'b1 || io_LSWB_lsures !== 64'h0) begin n_fail++; $display("FAIL rst_late_resp: valid %b req %b ready %b lsures %h expected 0 0 1 0", io_LSWB_valid, mem_req_valid, io_EXLS_ready, io_LSWB_lsures); end
  endtask

  initial begin
    test_reset;
    test_alu;
    test_loads;
    test_store;
    test_misalign;
    test_back_to_back_stall;
    test_reset_mid_wait;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
